mips_cache_wbuf_coalesce: RTL

Posted write buffer between the data-side CPU port and the Avalon memory port of the cache controller.
- Captures CPU stores in a FIFO so the CPU does not stall on memory write latency.
- Drains entries one at a time as Avalon writes while the controller holds `active`.
- Reports full/empty to the controller so it can stall the CPU and schedule the bus.

---
 rtl/mips_cache_wbuf_coalesce.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mips_cache_wbuf_coalesce.sv
// Posted write buffer between the CPU data port and the Avalon memory port.
// CPU stores go into a small FIFO. The FIFO drains one Avalon write at a time
// while the controller holds `active`. Bus outputs follow the head entry
// combinationally, and write_writeenable follows the drain state.
// Optional feature, macro WB_COALESCE_EN: a store to the same word as the
// tail-most entry is merged into that entry instead of taking a new slot.
module mips_cache_wbuf_coalesce #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            addr,
  input  logic                     write_en,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteenable,
  input  logic                     active,
  input  logic                     waitrequest,
  output logic [AW-1:0]            write_addr,
  output logic [31:0]              write_data,
  output logic [3:0]               write_byteenable,
  output logic                     write_writeenable,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;

  logic [1:0]    state_reg, state_next;
  logic [PW-1:0] head_reg, tail_reg, last_idx;
  logic [CW-1:0] count_reg, count_next;

  // Word address only; the byte offset is never stored.
  logic [AW-3:0] addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    be_mem   [DEPTH];

  logic          pop, store_valid, merge, alloc, draining;
  logic [31:0]   merged_data;
  logic [3:0]    merged_be;

  // The low address bits select a byte within the word and play no part here.
  logic          addr_lo_unused;
  assign addr_lo_unused = ^addr[1:0];

  assign draining    = (state_reg == ST_DRAIN);
  assign pop         = draining && !waitrequest;
  assign store_valid = write_en && (byteenable != 4'b0000);
  assign last_idx    = tail_reg - PW'(1);
  assign full        = (count_reg == FULL_CNT);
  assign empty       = (count_reg == '0);
  assign count       = count_reg;
  assign state_out   = state_reg;

`ifdef WB_COALESCE_EN
  // Merge into the newest entry when the word matches. The head is excluded
  // while it sits on the bus, because it must stay stable.
  assign merge = store_valid && !empty &&
                 (addr_mem[last_idx] == addr[AW-1:2]) &&
                 !(draining && (last_idx == head_reg));
`else
  assign merge = 1'b0;
`endif

  assign alloc      = store_valid && !merge && (!full || pop);
  assign count_next = count_reg + CW'(alloc) - CW'(pop);

  // Byte-lane merge of the incoming store over the tail-most entry.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_data[gi*8 +: 8] = byteenable[gi] ? writedata[gi*8 +: 8]
                                                     : data_mem[last_idx][gi*8 +: 8];
    end
  endgenerate
  assign merged_be = be_mem[last_idx] | byteenable;

  // Per-entry storage: allocate at the tail or merge into the tail-most entry.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [PW-1:0] IDX = PW'(gi);
      // Entry register update; cleared on reset so the bus reads 0.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          addr_mem[gi] <= '0;
          data_mem[gi] <= '0;
          be_mem[gi]   <= '0;
        end else if (alloc && (tail_reg == IDX)) begin
          addr_mem[gi] <= addr[AW-1:2];
          data_mem[gi] <= writedata;
          be_mem[gi]   <= byteenable;
        end else if (merge && (last_idx == IDX)) begin
          data_mem[gi] <= merged_data;
          be_mem[gi]   <= merged_be;
        end
      end
    end
  endgenerate

  // Drain FSM: hold through waitrequest, run back-to-back while there is work.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (active && !empty) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!waitrequest && !(active && (count_next != '0))) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pointers, occupancy and state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (pop)   head_reg <= head_reg + PW'(1);
      if (alloc) tail_reg <= tail_reg + PW'(1);
    end
  end

  assign write_addr        = {addr_mem[head_reg], 2'b00};
  assign write_data        = data_mem[head_reg];
  assign write_byteenable  = be_mem[head_reg];
  assign write_writeenable = draining;

endmodule
